// File: rtl/axil_mem_arbiter_pkg.sv
// rtl/axil_mem_arbiter_pkg.sv - shared widths, response codes and state/grant types for the memory arbiter
package axil_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DATA_DEPTH = 64;
  localparam int ADDR_WIDTH = 7;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int RESP_WIDTH = 2;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    RSP
  } arb_state_t;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } grant_t;

endpackage

// File: rtl/axil_mem_arbiter_if.sv
// rtl/axil_mem_arbiter_if.sv - requester and memory-port signals of the arbiter, with master/slave views
interface axil_mem_arbiter_if;
  import axil_pkg::*;

  // write requester
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wdone;
  logic [RESP_WIDTH-1:0] wresp;

  // read requester
  logic                  ren;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  mready;
  logic [DATA_WIDTH-1:0] mdata;
  logic [RESP_WIDTH-1:0] mresp;

  // single-port memory
  logic                  mem_cs;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_WIDTH-1:0] mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // requesters plus memory model side
  modport master (
    output wen, waddr, wdata, wstrb, ren, raddr, mem_rdata,
    input  wdone, wresp, mready, mdata, mresp,
    input  mem_cs, mem_we, mem_addr, mem_wdata, mem_be
  );

  // arbiter side
  modport slave (
    input  wen, waddr, wdata, wstrb, ren, raddr, mem_rdata,
    output wdone, wresp, mready, mdata, mresp,
    output mem_cs, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/axil_rr_arb2.sv
// rtl/axil_rr_arb2.sv - 2-way write/read picker; round-robin by default, read-first when AXIL_ARB_RD_PRIO_EN is defined
module axil_rr_arb2
  import axil_pkg::*;
(
  input  logic   req_wr,
  input  logic   req_rd,
  input  grant_t last_grant,
  output grant_t grant
);

`ifdef AXIL_ARB_RD_PRIO_EN
  // fixed priority: a pending read always beats a pending write
  always_comb begin
    grant = req_rd ? GNT_RD : GNT_WR;
  end
`else
  // round-robin: on a tie, serve the side that was not served last
  always_comb begin
    grant = GNT_WR;
    if (req_wr && req_rd) begin
      grant = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
    end else if (req_rd) begin
      grant = GNT_RD;
    end
  end
`endif

endmodule

// File: rtl/axil_mem_arbiter.sv
// rtl/axil_mem_arbiter.sv - shares one single-port memory between write and read paths (AXIL_ARB_RD_PRIO_EN selects read priority)
module axil_mem_arbiter
  import axil_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  axil_mem_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = DATA_DEPTH[ADDR_WIDTH:0];

  arb_state_t state, state_nxt;
  grant_t     pick, cur_grant, last_grant;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [STRB_WIDTH-1:0] mem_be_q;
  logic [DATA_WIDTH-1:0] mdata_q;
  logic [RESP_WIDTH-1:0] mresp_q;
  logic [RESP_WIDTH-1:0] wresp_q;

  logic                  any_req;
  logic                  grant_fire;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] req_addr;

  axil_rr_arb2 u_arb (
    .req_wr     (bus.wen),
    .req_rd     (bus.ren),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign any_req    = bus.wen | bus.ren;
  assign grant_fire = (state == IDLE) && any_req;
  assign req_addr   = (pick == GNT_RD) ? bus.raddr : bus.waddr;
  assign addr_err   = {1'b0, req_addr} >= DEPTH_L;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: out-of-range grants skip the memory and go straight to the response
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (addr_err)             state_nxt = RSP;
          else if (pick == GNT_RD)  state_nxt = RD;
          else                      state_nxt = WR;
        end
      end
      WR:      state_nxt = RSP;
      RD:      state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // grant bookkeeping, request latches and held response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_grant   <= GNT_WR;
      last_grant  <= GNT_WR;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mdata_q     <= '0;
      mresp_q     <= '0;
      wresp_q     <= '0;
    end else begin
      if (grant_fire) begin
        cur_grant  <= pick;
`ifndef AXIL_ARB_RD_PRIO_EN
        last_grant <= pick;
`endif
        mem_addr_q <= req_addr;
        if (pick == GNT_WR) begin
          mem_wdata_q <= bus.wdata;
          mem_be_q    <= bus.wstrb;
        end else begin
          mem_wdata_q <= '0;
          mem_be_q    <= '0;
        end
        if (addr_err) begin
          if (pick == GNT_WR) begin
            wresp_q <= RESP_SLVERR;
          end else begin
            mresp_q <= RESP_SLVERR;
            mdata_q <= '0;
          end
        end
      end
      if (state == WR) begin
        wresp_q <= RESP_OKAY;
      end
      if (state == RD_WAIT) begin
        mdata_q <= bus.mem_rdata;
        mresp_q <= RESP_OKAY;
      end
    end
  end

  assign bus.mem_cs    = (state == WR) || (state == RD);
  assign bus.mem_we    = (state == WR);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

  assign bus.wdone  = (state == RSP) && (cur_grant == GNT_WR);
  assign bus.mready = (state == RSP) && (cur_grant == GNT_RD);
  assign bus.wresp  = wresp_q;
  assign bus.mresp  = mresp_q;
  assign bus.mdata  = mdata_q;

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// tb/tb_axil_mem_arbiter.sv - directed self-checking bench for axil_mem_arbiter
module tb_axil_mem_arbiter;
  import axil_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  axil_mem_arbiter_if bus ();

  axil_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];

  // memory model: byte-enabled writes, one-cycle registered reads
  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be[b]) mem[bus.mem_addr[5:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
    end
    if (bus.mem_cs && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr[5:0]];
  end

  task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [1:0] resp, output int cs_cnt);
    lat = -1; resp = 2'bxx; cs_cnt = 0;
    @(posedge clk); #1;
    bus.wen = 1'b1; bus.waddr = a; bus.wdata = d; bus.wstrb = s;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_cs) cs_cnt++;
      if (bus.wdone) begin lat = i; resp = bus.wresp; break; end
    end
    @(posedge clk); #1;
    bus.wen = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a, output int lat, output logic [31:0] d,
                         output logic [1:0] resp, output int cs_cnt);
    lat = -1; resp = 2'bxx; d = 'x; cs_cnt = 0;
    @(posedge clk); #1;
    bus.ren = 1'b1; bus.raddr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_cs) cs_cnt++;
      if (bus.mready) begin lat = i; d = bus.mdata; resp = bus.mresp; break; end
    end
    @(posedge clk); #1;
    bus.ren = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] ov;
    rst = 1'b1;
    bus.wen = 0; bus.waddr = 0; bus.wdata = 0; bus.wstrb = 0;
    bus.ren = 0; bus.raddr = 0; bus.mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ov = {28'd0, bus.wdone, bus.mready, bus.mem_cs, bus.mem_we};
    checks++; if (ov !== 32'd0) begin errors++; $display("FAIL reset_strobes: got %h expected 0", ov); end
    checks++; if (bus.mem_addr !== 7'd0 || bus.mem_be !== 4'd0 || bus.mem_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_mem_port: addr %h be %h wdata %h expected 0", bus.mem_addr, bus.mem_be, bus.mem_wdata); end
    checks++; if (bus.mdata !== 32'd0 || bus.mresp !== 2'd0 || bus.wresp !== 2'd0) begin
      errors++; $display("FAIL reset_resp: mdata %h mresp %b wresp %b expected 0", bus.mdata, bus.mresp, bus.wresp); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write;
    @(posedge clk); #1;
    bus.wen = 1'b1; bus.waddr = 7'd5; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    @(negedge clk);
    checks++; if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL wr_c0_cs: got %b expected 0", bus.mem_cs); end
    @(negedge clk);
    checks++; if ({bus.mem_cs, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 7'd5}) begin
      errors++; $display("FAIL wr_c1_port: cs %b we %b addr %0d expected 1 1 5", bus.mem_cs, bus.mem_we, bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hDEADBEEF || bus.mem_be !== 4'hF) begin
      errors++; $display("FAIL wr_c1_data: wdata %h be %h expected deadbeef f", bus.mem_wdata, bus.mem_be); end
    @(negedge clk);
    checks++; if ({bus.wdone, bus.wresp, bus.mready, bus.mem_cs} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL wr_c2_done: wdone %b wresp %b mready %b cs %b expected 1 00 0 0", bus.wdone, bus.wresp, bus.mready, bus.mem_cs); end
    @(posedge clk); #1;
    bus.wen = 1'b0;
    @(negedge clk);
    checks++; if (bus.wdone !== 1'b0) begin errors++; $display("FAIL wr_single_pulse: got %b expected 0", bus.wdone); end
  endtask

  task automatic test_read;
    int lat, cs; logic [31:0] d; logic [1:0] r;
    do_read(7'd5, lat, d, r, cs);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (d !== 32'hDEADBEEF || r !== 2'b00) begin errors++; $display("FAIL rd_data: got %h/%b expected deadbeef/00", d, r); end
    checks++; if (cs !== 1) begin errors++; $display("FAIL rd_cs_cycles: got %0d expected 1", cs); end
    do_write(7'd5, 32'h12345678, 4'h3, lat, r, cs);
    checks++; if (lat !== 2 || r !== 2'b00) begin errors++; $display("FAIL wr_strb_done: lat %0d resp %b expected 2 00", lat, r); end
    do_read(7'd5, lat, d, r, cs);
    checks++; if (d !== 32'hDEAD5678) begin errors++; $display("FAIL rd_strb_merge: got %h expected dead5678", d); end
    checks++; if (bus.mdata !== 32'hDEAD5678 || bus.mresp !== 2'b00) begin
      errors++; $display("FAIL rd_hold: mdata %h mresp %b expected dead5678 00", bus.mdata, bus.mresp); end
  endtask

  task automatic test_tie;
    int seq[$]; int exp_seq[4]; logic both; logic got_cs; logic first_we; logic data_ok;
    int lat, cs; logic [1:0] r;
`ifdef AXIL_ARB_RD_PRIO_EN
    exp_seq = '{1, 1, 1, 1};
`else
    exp_seq = '{1, 0, 1, 0};
`endif
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    bus.wen = 1'b1; bus.waddr = 7'd10; bus.wdata = 32'hCAFE0010; bus.wstrb = 4'hF;
    bus.ren = 1'b1; bus.raddr = 7'd5;
    both = 0; got_cs = 0; first_we = 1'bx; data_ok = 1;
    for (int i = 0; i < 60 && seq.size() < 4; i++) begin
      @(negedge clk);
      if (bus.mem_cs && !got_cs) begin got_cs = 1; first_we = bus.mem_we; end
      if (bus.wdone && bus.mready) both = 1;
      if (bus.mready) begin seq.push_back(1); if (bus.mdata !== 32'hDEAD5678) data_ok = 0; end
      if (bus.wdone) seq.push_back(0);
    end
    @(posedge clk); #1;
    bus.ren = 1'b0; bus.wen = 1'b0;
    checks++; if (seq.size() !== 4) begin errors++; $display("FAIL tie_timeout: got %0d done pulses expected 4", seq.size()); end
    checks++; if (first_we !== 1'b0) begin errors++; $display("FAIL tie_first_grant: mem_we %b expected 0 (read)", first_we); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < seq.size() && seq[k] != exp_seq[k] || k >= seq.size()) begin
        errors++; $display("FAIL tie_order_%0d: got %0d expected %0d (1=rd 0=wr)", k, (k < seq.size()) ? seq[k] : -1, exp_seq[k]); end
    end
    checks++; if (both !== 1'b0 || data_ok !== 1'b1) begin
      errors++; $display("FAIL tie_pulses: overlap %b data_ok %b expected 0 1", both, data_ok); end
    do_write(7'd10, 32'hCAFE0010, 4'hF, lat, r, cs);
    checks++; if (lat !== 2 || r !== 2'b00) begin errors++; $display("FAIL tie_write_after: lat %0d resp %b expected 2 00", lat, r); end
  endtask

  task automatic test_out_of_range;
    int lat, cs; logic [31:0] d; logic [1:0] r;
    do_read(7'd64, lat, d, r, cs);
    checks++; if (lat !== 1) begin errors++; $display("FAIL oor_rd_latency: got %0d expected 1", lat); end
    checks++; if (r !== 2'b10 || d !== 32'd0) begin errors++; $display("FAIL oor_rd_resp: got %b/%h expected 10/0", r, d); end
    checks++; if (cs !== 0) begin errors++; $display("FAIL oor_rd_cs: got %0d cycles expected 0", cs); end
    do_write(7'd100, 32'h55AA55AA, 4'hF, lat, r, cs);
    checks++; if (lat !== 1 || r !== 2'b10) begin errors++; $display("FAIL oor_wr_resp: lat %0d resp %b expected 1 10", lat, r); end
    checks++; if (cs !== 0) begin errors++; $display("FAIL oor_wr_cs: got %0d cycles expected 0", cs); end
    checks++; if (bus.mresp !== 2'b10 || bus.mdata !== 32'd0 || bus.wresp !== 2'b10) begin
      errors++; $display("FAIL oor_hold: mresp %b mdata %h wresp %b expected 10 0 10", bus.mresp, bus.mdata, bus.wresp); end
  endtask

  task automatic test_reset_abort;
    int lat, cs, pulses; logic [31:0] d; logic [1:0] r; logic [31:0] ov;
    @(posedge clk); #1;
    bus.ren = 1'b1; bus.raddr = 7'd5;
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++; if (bus.mem_cs !== 1'b0 || bus.mready !== 1'b0 || bus.mem_addr !== 7'd5) begin
      errors++; $display("FAIL abort_in_rd_wait: cs %b mready %b addr %0d expected 0 0 5", bus.mem_cs, bus.mready, bus.mem_addr); end
    #1 rst = 1'b1;
    #1;
    ov = {24'd0, bus.mem_addr, bus.mready};
    checks++; if (ov !== 32'd0 || bus.mresp !== 2'b00 || bus.mdata !== 32'd0) begin
      errors++; $display("FAIL abort_outputs: addr/mready %h mresp %b mdata %h expected 0", ov, bus.mresp, bus.mdata); end
    bus.ren = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (bus.mready || bus.mem_cs) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", pulses); end
    do_read(7'd5, lat, d, r, cs);
    checks++; if (lat !== 3 || d !== 32'hDEAD5678 || r !== 2'b00) begin
      errors++; $display("FAIL abort_fresh_read: lat %0d data %h resp %b expected 3 dead5678 00", lat, d, r); end
  endtask

  task automatic test_back_to_back;
    int gap, extra, found; logic [31:0] d;
    @(posedge clk); #1;
    bus.ren = 1'b1; bus.raddr = 7'd5;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin @(negedge clk); if (bus.mready) found = 1; end
    checks++; if (found !== 1) begin errors++; $display("FAIL b2b_first_done: got %0d expected 1", found); end
    @(posedge clk); #1;
    bus.raddr = 7'd10;
    gap = -1; extra = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.mready) extra++;
      if (bus.mem_cs) begin gap = i; break; end
    end
    checks++; if (gap !== 2) begin errors++; $display("FAIL b2b_gap: got %0d expected 2", gap); end
    found = 0; d = 'x;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk); if (bus.mready) begin found = 1; d = bus.mdata; end
    end
    @(posedge clk); #1;
    bus.ren = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (bus.mready || bus.mem_cs) extra++; end
    checks++; if (found !== 1 || d !== 32'hCAFE0010) begin
      errors++; $display("FAIL b2b_second_read: done %0d data %h expected 1 cafe0010", found, d); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_duplicates: got %0d extra cycles expected 0", extra); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_out_of_range();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
